umi_loc_mem: RTL and testbench

- Parametrised, synthesizable memory target for the umi_endpoint local (loc_*) interface.
- Replaces ad-hoc 64-bit bench memories.
- Adds configurable data width and depth, byte-granular writes from size/len, and programmable wait states via loc_ready.
- Adds UMI atomic read-modify-write.
- Used in example benches and as a scratchpad behind umi_endpoint in small SoC tiles.

---
 rtl/umi_loc_mem.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_umi_loc_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/umi_loc_mem.sv
// umi_loc_mem: parametrised scratchpad target for the umi_endpoint loc_* interface.
// Define UMI_LOC_MEM_ATOMIC_EN to build the atomic read-modify-write (AMO) path.
module umi_loc_mem #(
  parameter int DW          = 256,
  parameter int AW          = 64,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter     MEMFILE     = ""
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] loc_addr,
  input  logic          loc_write,
  input  logic          loc_read,
  input  logic          loc_atomic,
  input  logic [7:0]    loc_atype,
  input  logic [2:0]    loc_size,
  input  logic [7:0]    loc_len,
  input  logic [DW-1:0] loc_wrdata,
  output logic [DW-1:0] loc_rddata,
  output logic          loc_ready
);

  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_AMO  = 2'd2
  } state_t;

  logic [DW-1:0]   r_mem [DEPTH];
  state_t          r_state;
  state_t          w_state_nx;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nx;
  logic            r_ready;
  logic [DW-1:0]   r_rddata;

  logic [IW-1:0]   w_idx;
  logic [OFFW-1:0] w_off;
  logic [DW-1:0]   w_word;
  logic [DW-1:0]   w_word_shr;
  logic            w_accept;
  logic            w_acc_wr;
  logic            w_acc_rd;
  logic            w_acc_amo;
  logic [16:0]     w_nbytes;
  logic [NB-1:0]   w_wr_be;
  logic [DW-1:0]   w_wr_data;

  logic            w_mem_we;
  logic [IW-1:0]   w_mem_idx;
  logic [NB-1:0]   w_mem_be;
  logic [DW-1:0]   w_mem_wdata;
  logic            w_unused_ok;

  assign w_idx      = loc_addr[OFFW +: IW];
  assign w_off      = loc_addr[OFFW-1:0];
  assign w_word     = r_mem[w_idx];
  assign w_word_shr = w_word >> {w_off, 3'b000};
  assign w_nbytes   = ({9'd0, loc_len} + 17'd1) << loc_size;
  assign w_wr_data  = loc_wrdata << {w_off, 3'b000};
  assign w_accept   = r_ready & (loc_write | loc_read | loc_atomic);

  assign loc_ready  = r_ready;
  assign loc_rddata = r_rddata;

`ifdef UMI_LOC_MEM_ATOMIC_EN
  logic [IW-1:0]   r_amo_idx;
  logic [OFFW-1:0] r_amo_off;
  logic [1:0]      r_amo_sz;
  logic [7:0]      r_amo_type;
  logic [63:0]     r_amo_opnd;
  logic [1:0]      w_amo_sz;
  logic [OFFW-1:0] w_amo_off;
  logic [DW-1:0]   w_amo_word_shr;
  logic [63:0]     w_amo_old;
  logic [63:0]     w_amo_res;
  logic [NB-1:0]   w_amo_be;
  logic [DW-1:0]   w_amo_wdata;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] size_bmask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Signed compares sign-extend from the operand width by shifting the sign bit to bit 63.
  function automatic logic [63:0] amo_alu(input logic [7:0]  atype,
                                          input logic [1:0]  sz,
                                          input logic [63:0] old_v,
                                          input logic [63:0] opd_v);
    logic [63:0]        mask;
    logic [63:0]        old_m;
    logic [63:0]        opd_m;
    logic [63:0]        res;
    logic [6:0]         sh;
    logic signed [63:0] old_s;
    logic signed [63:0] opd_s;
    mask  = size_mask(sz);
    old_m = old_v & mask;
    opd_m = opd_v & mask;
    sh    = 7'd64 - (7'd8 << sz);
    old_s = $signed(old_m << sh) >>> sh;
    opd_s = $signed(opd_m << sh) >>> sh;
    case (atype)
      8'h00:   res = old_m + opd_m;
      8'h01:   res = old_m & opd_m;
      8'h02:   res = old_m | opd_m;
      8'h03:   res = old_m ^ opd_m;
      8'h04:   res = (old_s > opd_s) ? old_m : opd_m;
      8'h05:   res = (old_s < opd_s) ? old_m : opd_m;
      8'h06:   res = (old_m > opd_m) ? old_m : opd_m;
      8'h07:   res = (old_m < opd_m) ? old_m : opd_m;
      8'h08:   res = opd_m;
      default: res = old_m;
    endcase
    return res & mask;
  endfunction

  assign w_acc_amo      = w_accept & loc_atomic;
  assign w_acc_wr       = w_accept & loc_write & ~loc_atomic;
  assign w_acc_rd       = w_accept & loc_read & ~loc_atomic;
  assign w_amo_sz       = (loc_size > 3'd3) ? 2'd3 : loc_size[1:0];
  assign w_amo_off      = w_off & ({OFFW{1'b1}} << w_amo_sz);
  assign w_amo_word_shr = w_word >> {w_amo_off, 3'b000};
  assign w_amo_old      = w_amo_word_shr[63:0] & size_mask(w_amo_sz);
  // The old value sits in r_rddata during AMO, so it doubles as the ALU input.
  assign w_amo_res      = amo_alu(r_amo_type, r_amo_sz, r_rddata[63:0], r_amo_opnd);
  assign w_amo_be       = NB'(size_bmask(r_amo_sz)) << r_amo_off;
  assign w_amo_wdata    = DW'(w_amo_res) << {r_amo_off, 3'b000};
  assign w_unused_ok    = ^loc_addr[AW-1:OFFW+IW];

  // Capture the atomic context for the writeback cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_amo_idx  <= '0;
      r_amo_off  <= '0;
      r_amo_sz   <= 2'd0;
      r_amo_type <= 8'd0;
      r_amo_opnd <= 64'd0;
    end else if (w_acc_amo) begin
      r_amo_idx  <= w_idx;
      r_amo_off  <= w_amo_off;
      r_amo_sz   <= w_amo_sz;
      r_amo_type <= loc_atype;
      r_amo_opnd <= loc_wrdata[63:0];
    end else begin
      r_amo_idx  <= r_amo_idx;
      r_amo_off  <= r_amo_off;
      r_amo_sz   <= r_amo_sz;
      r_amo_type <= r_amo_type;
      r_amo_opnd <= r_amo_opnd;
    end
  end

  // Memory write port: AMO writeback or a normal accepted write
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_be    = w_wr_be;
    w_mem_wdata = w_wr_data;
    if (r_state == ST_AMO) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_amo_idx;
      w_mem_be    = w_amo_be;
      w_mem_wdata = w_amo_wdata;
    end else begin
      w_mem_we    = w_acc_wr;
      w_mem_idx   = w_idx;
      w_mem_be    = w_wr_be;
      w_mem_wdata = w_wr_data;
    end
  end
`else
  // Without the AMO path an atomic request is served as a plain read.
  assign w_acc_amo   = 1'b0;
  assign w_acc_wr    = w_accept & loc_write & ~loc_atomic;
  assign w_acc_rd    = w_accept & (loc_read | loc_atomic);
  assign w_unused_ok = ^{loc_addr[AW-1:OFFW+IW], loc_atype};

  // Memory write port: normal accepted write only
  always_comb begin
    w_mem_we    = w_acc_wr;
    w_mem_idx   = w_idx;
    w_mem_be    = w_wr_be;
    w_mem_wdata = w_wr_data;
  end
`endif

  // Byte enables for [offset, offset+nbytes), clipped at the word end
  always_comb begin
    w_wr_be = '0;
    for (int j = 0; j < NB; j++) begin
      w_wr_be[j] = (j >= int'(w_off)) && (j < int'(w_off) + int'(w_nbytes));
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_amo) begin
          w_state_nx = ST_AMO;
        end else if ((w_acc_wr || w_acc_rd) && (WAIT_CYCLES > 0)) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = WC;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx   = r_cnt - 4'd1;
        end
      end
      ST_AMO: begin
        if (WAIT_CYCLES > 0) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = WC;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter and ready register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ready <= (w_state_nx == ST_IDLE);
    end
  end

  // Read data register; the memory is read before any same-edge write lands
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rddata <= '0;
    end else if (w_acc_rd) begin
      r_rddata <= w_word_shr;
`ifdef UMI_LOC_MEM_ATOMIC_EN
    end else if (w_acc_amo) begin
      r_rddata <= DW'(w_amo_old);
`endif
    end else begin
      r_rddata <= r_rddata;
    end
  end

  // Byte-granular memory write; contents are deliberately not reset
  always @(posedge clk) begin
    if (w_mem_we) begin
      for (int j = 0; j < NB; j++) begin
        if (w_mem_be[j]) begin
          r_mem[w_mem_idx][8*j +: 8] <= w_mem_wdata[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_umi_loc_mem.sv
// Randomised self-checking bench for umi_loc_mem against a byte-array reference model.
module tb_umi_loc_mem;

  localparam int DW    = 256;
  localparam int NB    = 32;
  localparam int AW    = 64;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          nreset;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_write, a_read, a_atomic, b_write, b_read, b_atomic;
  logic [7:0]    a_atype, b_atype, a_len, b_len;
  logic [2:0]    a_size, b_size;
  logic [DW-1:0] a_wrdata, b_wrdata, a_rddata, b_rddata;
  logic          a_ready, b_ready;

  int            n_chk = 0;
  int            n_err = 0;
  logic [7:0]    ref_mem [DEPTH*NB];
  logic [255:0]  exp_hold;
  logic [255:0]  got;

  always #5 clk = ~clk;

  umi_loc_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0), .MEMFILE("")) u_dut0 (
    .clk(clk), .nreset(nreset), .loc_addr(a_addr), .loc_write(a_write), .loc_read(a_read),
    .loc_atomic(a_atomic), .loc_atype(a_atype), .loc_size(a_size), .loc_len(a_len),
    .loc_wrdata(a_wrdata), .loc_rddata(a_rddata), .loc_ready(a_ready)
  );

  umi_loc_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2), .MEMFILE("")) u_dut2 (
    .clk(clk), .nreset(nreset), .loc_addr(b_addr), .loc_write(b_write), .loc_read(b_read),
    .loc_atomic(b_atomic), .loc_atype(b_atype), .loc_size(b_size), .loc_len(b_len),
    .loc_wrdata(b_wrdata), .loc_rddata(b_rddata), .loc_ready(b_ready)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] ref_read(input int idx, input int off);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) if (off + i < NB) r[8*i +: 8] = ref_mem[idx*NB + off + i];
    return r;
  endfunction

  function automatic longint sx(input logic [63:0] v, input int n);
    if (n == 8) return $signed(v);
    else if (v[8*n-1]) return longint'(v) - (longint'(1) << (8*n));
    else return longint'(v);
  endfunction

  // Applies one request to the reference model; returns the expected read data.
  task automatic model_req(input bit wr, input bit rd, input bit at, input logic [7:0] atype,
                           input logic [63:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [255:0] data, output logic [255:0] exp_rd,
                           output bit upd, output bit drop);
    int idx, off, n, aoff, nbytes;
    logic [63:0] old, opd, res, mask;
    idx = int'(addr[12:5]);
    off = int'(addr[4:0]);
    upd = 1'b0; drop = 1'b0; exp_rd = '0;
    if (at) begin
`ifdef UMI_LOC_MEM_ATOMIC_EN
      n    = 1 << ((size > 3'd3) ? 3 : int'(size));
      aoff = off - (off % n);
      old  = '0;
      for (int i = 0; i < n; i++) old[8*i +: 8] = ref_mem[idx*NB + aoff + i];
      mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*n)) - 64'd1);
      opd  = data[63:0] & mask;
      case (atype)
        8'h00: res = (old + opd) & mask;
        8'h01: res = old & opd;
        8'h02: res = old | opd;
        8'h03: res = old ^ opd;
        8'h04: res = (sx(old, n) >= sx(opd, n)) ? old : opd;
        8'h05: res = (sx(old, n) <= sx(opd, n)) ? old : opd;
        8'h06: res = (old >= opd) ? old : opd;
        8'h07: res = (old <= opd) ? old : opd;
        8'h08: res = opd;
        default: res = old;
      endcase
      for (int i = 0; i < n; i++) ref_mem[idx*NB + aoff + i] = res[8*i +: 8];
      exp_rd = {192'd0, old};
      upd = 1'b1; drop = 1'b1;
`else
      exp_rd = ref_read(idx, off);
      upd = 1'b1;
`endif
    end else begin
      if (rd) begin
        exp_rd = ref_read(idx, off);
        upd = 1'b1;
      end
      if (wr) begin
        nbytes = (int'(len) + 1) << size;
        for (int i = 0; i < nbytes && off + i < NB; i++) ref_mem[idx*NB + off + i] = data[8*i +: 8];
      end
    end
  endtask

  // Issues one request on dut0 (called at posedge+1) and checks data and ready timing.
  task automatic do_req(input string tag, input bit wr, input bit rd, input bit at,
                        input logic [7:0] atype, input logic [63:0] addr, input logic [2:0] size,
                        input logic [7:0] len, input logic [255:0] data, output logic [255:0] obs);
    logic [255:0] exp_rd;
    bit upd, drop;
    int guard;
    a_addr = addr; a_atype = atype; a_size = size; a_len = len; a_wrdata = data;
    a_write = wr; a_read = rd; a_atomic = at;
    guard = 0;
    while (a_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check_val({tag, "_ready_timeout"}, 256'(a_ready), 256'd1);
    model_req(wr, rd, at, atype, addr, size, len, data, exp_rd, upd, drop);
    @(posedge clk); #1;
    a_write = 1'b0; a_read = 1'b0; a_atomic = 1'b0;
    obs = a_rddata;
    if (upd) exp_hold = exp_rd;
    check_val({tag, "_rddata"}, a_rddata, exp_hold);
    check_val({tag, "_ready"}, 256'(a_ready), drop ? 256'd0 : 256'd1);
    if (drop) begin
      @(posedge clk); #1;
      check_val({tag, "_ready_back"}, 256'(a_ready), 256'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int acc;
    bit prev;
    bit wr, rd, at;
    logic [255:0] rnd;
    nreset = 1'b0;
    a_addr = '0; a_write = 1'b0; a_read = 1'b0; a_atomic = 1'b0; a_atype = '0; a_size = '0; a_len = '0; a_wrdata = '0;
    b_addr = '0; b_write = 1'b0; b_read = 1'b0; b_atomic = 1'b0; b_atype = '0; b_size = '0; b_len = '0; b_wrdata = '0;
    exp_hold = '0;

    repeat (5) @(posedge clk);
    #1;
    check_val("rst_ready", 256'(a_ready), 256'd0);
    check_val("rst_rddata", a_rddata, 256'd0);
    check_val("rst_ready_w2", 256'(b_ready), 256'd0);
    nreset = 1'b1;
    #1;
    check_val("rel_ready_before_edge", 256'(a_ready), 256'd0);
    @(posedge clk); #1;
    check_val("rel_ready", 256'(a_ready), 256'd1);
    check_val("rel_ready_w2", 256'(b_ready), 256'd1);

    // Back-to-back reads on the WAIT_CYCLES=2 instance
    b_addr = 64'h0; b_read = 1'b1; acc = 0;
    for (int k = 0; k < 9; k++) begin
      prev = b_ready;
      @(posedge clk); #1;
      if (prev) acc++;
      check_val($sformatf("wait_ready_%0d", k), 256'(b_ready), 256'(k % 3 == 2));
    end
    b_read = 1'b0;
    check_val("wait_accepts", 256'(acc), 256'd3);

    for (int w = 0; w < DEPTH; w++) do_req("init", 1'b1, 1'b0, 1'b0, 8'h00, 64'(w * NB), 3'd5, 8'd0, 256'd0, got);

    do_req("wr64", 1'b1, 1'b0, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'h1122334455667788, got);
    do_req("rd64", 1'b0, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'd0, got);
    check_val("rd64_value", got, 256'h1122334455667788);
    do_req("wr_part", 1'b1, 1'b0, 1'b0, 8'h00, 64'h12, 3'd0, 8'd1, 256'hBEEF, got);
    do_req("rd_part", 1'b0, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'd0, got);
    check_val("rd_part_value", got, 256'h11223344BEEF7788);
    do_req("wr_wrap", 1'b1, 1'b0, 1'b0, 8'h00, 64'h2000, 3'd0, 8'd0, 256'hA5, got);
    do_req("rd_wrap", 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 3'd0, 8'd0, 256'd0, got);
    check_val("rd_wrap_value", 256'(got[7:0]), 256'hA5);

    do_req("amo_add", 1'b0, 1'b0, 1'b1, 8'h00, 64'h10, 3'd2, 8'd0, 256'd1, got);
`ifdef UMI_LOC_MEM_ATOMIC_EN
    check_val("amo_add_old", got, 256'hBEEF7788);
`else
    check_val("amo_add_old", got, 256'h11223344BEEF7788);
`endif
    do_req("amo_min", 1'b0, 1'b0, 1'b1, 8'h05, 64'h14, 3'd2, 8'd0, 256'hFFFFFFFF, got);
    do_req("amo_minu", 1'b0, 1'b0, 1'b1, 8'h07, 64'h10, 3'd2, 8'd0, 256'hFFFFFFFF, got);
    do_req("rd_amo", 1'b0, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'd0, got);
`ifdef UMI_LOC_MEM_ATOMIC_EN
    check_val("rd_amo_value", got, 256'hFFFFFFFFBEEF7789);
`else
    check_val("rd_amo_value", got, 256'h11223344BEEF7788);
`endif
    do_req("wr_rd", 1'b1, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'hCAFEF00DDEADBEEF, got);
    do_req("rd_after_wr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'd0, got);
    check_val("rd_after_wr_rd_value", 256'(got[63:0]), 256'hCAFEF00DDEADBEEF);

    // Reset while an atomic writeback is pending: memory must stay untouched
    a_addr = 64'h10; a_size = 3'd2; a_atype = 8'h00; a_len = 8'd0; a_wrdata = 256'd5; a_atomic = 1'b1;
    @(posedge clk); #1;
    a_atomic = 1'b0;
    nreset = 1'b0;
    #1;
    check_val("rst_mid_rddata", a_rddata, 256'd0);
    check_val("rst_mid_ready", 256'(a_ready), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_ready_back", 256'(a_ready), 256'd1);
    exp_hold = '0;
    do_req("rd_after_rst", 1'b0, 1'b1, 1'b0, 8'h00, 64'h10, 3'd3, 8'd0, 256'd0, got);

    for (int it = 0; it < 300; it++) begin
      for (int q = 0; q < 8; q++) rnd[32*q +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0:       begin wr = 1'b1; rd = 1'b0; at = 1'b0; end
        1:       begin wr = 1'b0; rd = 1'b1; at = 1'b0; end
        2:       begin wr = 1'b1; rd = 1'b1; at = 1'b0; end
        default: begin wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); at = 1'b1; end
      endcase
      do_req($sformatf("rnd%0d", it), wr, rd, at, 8'($urandom_range(0, 10)),
             {$urandom, $urandom}, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3)), rnd, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
